// File: rtl/sa_autosa_glb_intr_ctrl.sv
// sa_autosa_glb_intr_ctrl: GLB interrupt SET/STATUS fields, overflow tracking and host interrupt generation
//
// Captures 16 engine done pulses (sdp, cdp, pdp, bdma, rubik, cdma_dat, cdma_wt, cacc,
// each with group 0 and group 1) into pending status bits. It also applies software
// set and write-1-to-clear, and raises one level interrupt for any unmasked pending bit.
// After each deassertion, the interrupt stays low for at least HOLDOFF_CYC cycles.
//
// Ports:
//   autosa_core_clk   in   1   core clock
//   autosa_core_rstn  in   1   asynchronous active-low reset
//   src_done          in  16   per-source done pulses
//   src_mask          in  16   per-source interrupt mask (1 = masked)
//   set_trigger       in   1   write strobe for INTR_SET_0
//   status_trigger    in   1   write strobe for INTR_STATUS_0 (write-1-to-clear)
//   reg_wr_data       in  32   CSB write data (sources 0..9 -> bits 0..9, 10..15 -> bits 16..21)
//   status            out 16   pending bits
//   sw_set            out 16   pending bits raised by software
//   ovf               out 16   sticky per-source overflow
//   evt_cnt           out 16   saturating count of cycles carrying any hardware done
//   intr_out          out  1   level interrupt to the host
//
// Optional feature macro: SA_GLB_INTR_COALESCE_EN adds a WAIT state that holds off
// assertion until COALESCE_CYC cycles after the first unmasked pending bit.
module sa_autosa_glb_intr_ctrl #(
    parameter int HOLDOFF_CYC  = 4,
    parameter int COALESCE_CYC = 16
) (
    input  logic        autosa_core_clk,
    input  logic        autosa_core_rstn,
    input  logic [15:0] src_done,
    input  logic [15:0] src_mask,
    input  logic        set_trigger,
    input  logic        status_trigger,
    input  logic [31:0] reg_wr_data,
    output logic [15:0] status,
    output logic [15:0] sw_set,
    output logic [15:0] ovf,
    output logic [15:0] evt_cnt,
    output logic        intr_out
);

    // One counter serves both holdoff and coalesce, so size it for the larger load.
    localparam int CNT_MAX = (HOLDOFF_CYC > COALESCE_CYC) ? HOLDOFF_CYC : COALESCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef SA_GLB_INTR_COALESCE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF, ST_WAIT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} state_t;
`endif

    logic [15:0]      r_status;
    logic [15:0]      r_sw_set;
    logic [15:0]      r_ovf;
    logic [15:0]      r_evt_cnt;
    logic             r_intr;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [15:0] w_wd;
    logic [15:0] w_sw_hit;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_ovf_new;
    logic        w_act;

    // The CSB field layout leaves a gap at bits 10..15, so the upper six sources start at bit 16.
    assign w_wd      = {reg_wr_data[21:16], reg_wr_data[9:0]};
    assign w_sw_hit  = {16{set_trigger}} & w_wd;
    assign w_set     = src_done | w_sw_hit;
    assign w_clr     = {16{status_trigger}} & w_wd;
    // A done that lands on an already-pending bit is lost unless software is clearing it now.
    assign w_ovf_new = src_done & r_status & ~w_clr;
    // The mask gates only the interrupt; status always captures.
    assign w_act     = |(r_status & ~src_mask);

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_status  <= '0;
            r_sw_set  <= '0;
            r_ovf     <= '0;
            r_evt_cnt <= '0;
        end else begin
            r_status  <= w_set | (r_status & ~w_clr);
            r_sw_set  <= w_sw_hit | (r_sw_set & ~w_clr);
            r_ovf     <= w_ovf_new | (r_ovf & ~w_clr);
            r_evt_cnt <= (|src_done && r_evt_cnt != 16'hFFFF) ? r_evt_cnt + 16'd1 : r_evt_cnt;
        end
    end

    // intr_out is registered alongside the state, so it is high exactly while in ASSERT.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_intr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef SA_GLB_INTR_COALESCE_EN
                    if (w_act) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(COALESCE_CYC - 1);
                    end
`else
                    if (w_act) begin
                        r_state <= ST_ASSERT;
                        r_intr  <= 1'b1;
                    end
`endif
                end
`ifdef SA_GLB_INTR_COALESCE_EN
                ST_WAIT: begin
                    // Later events do not restart the window; losing act abandons it.
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_ASSERT;
                        r_intr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                ST_ASSERT: begin
                    // Masking every pending bit drops act just like a clear does.
                    if (!w_act) begin
                        r_state <= ST_HOLDOFF;
                        r_cnt   <= CNT_W'(HOLDOFF_CYC - 1);
                        r_intr  <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign status   = r_status;
    assign sw_set   = r_sw_set;
    assign ovf      = r_ovf;
    assign evt_cnt  = r_evt_cnt;
    assign intr_out = r_intr;

endmodule

// File: tb/tb_sa_autosa_glb_intr_ctrl.sv
// tb_sa_autosa_glb_intr_ctrl: randomized self-checking bench against a behavioural model
module tb_sa_autosa_glb_intr_ctrl;

    localparam int HOLD = 4;
    localparam int COAL = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] src_done = '0;
    logic [15:0] src_mask = '0;
    logic        set_trigger = 1'b0;
    logic        status_trigger = 1'b0;
    logic [31:0] reg_wr_data = '0;
    logic [15:0] status, sw_set, ovf, evt_cnt;
    logic        intr_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_status = '0;
    logic [15:0] m_sw = '0;
    logic [15:0] m_ovf = '0;
    int          m_evt = 0;
    bit          m_intr = 1'b0;
    int          m_hold = 0;
`ifdef SA_GLB_INTR_COALESCE_EN
    int          m_run = 0;
`endif

    sa_autosa_glb_intr_ctrl #(.HOLDOFF_CYC(HOLD), .COALESCE_CYC(COAL)) dut (
        .autosa_core_clk(clk),
        .autosa_core_rstn(rstn),
        .src_done(src_done),
        .src_mask(src_mask),
        .set_trigger(set_trigger),
        .status_trigger(status_trigger),
        .reg_wr_data(reg_wr_data),
        .status(status),
        .sw_set(sw_set),
        .ovf(ovf),
        .evt_cnt(evt_cnt),
        .intr_out(intr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("status", 32'(status), 32'(m_status));
        chk("sw_set", 32'(sw_set), 32'(m_sw));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("evt_cnt", 32'(evt_cnt), 32'(m_evt));
        chk("intr_out", 32'(intr_out), 32'(m_intr));
    endtask

    task automatic model_reset();
        m_status = '0;
        m_sw = '0;
        m_ovf = '0;
        m_evt = 0;
        m_intr = 1'b0;
        m_hold = 0;
`ifdef SA_GLB_INTR_COALESCE_EN
        m_run = 0;
`endif
    endtask

    // One cycle of the reference: per-source rules, then the interrupt timing rules.
    task automatic model_step(input logic [15:0] d, input logic [15:0] mk,
                              input logic st, input logic ct, input logic [31:0] wd);
        bit act = 1'b0;
        for (int i = 0; i < 16; i++)
            if (m_status[i] && !mk[i]) act = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit w = wd[i < 10 ? i : i + 6];
            bit s = st && w;
            bit c = ct && w;
            m_ovf[i]    = (d[i] && m_status[i] && !c) || (m_ovf[i] && !c);
            m_sw[i]     = s || (m_sw[i] && !c);
            m_status[i] = d[i] || s || (m_status[i] && !c);
        end
        if (d != 0 && m_evt < 65535) m_evt++;
        if (m_intr) begin
            if (!act) begin
                m_intr = 1'b0;
                m_hold = HOLD;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
`ifdef SA_GLB_INTR_COALESCE_EN
            m_run  = act ? m_run + 1 : 0;
            m_intr = m_run > COAL;
            if (m_intr) m_run = 0;
`else
            m_intr = act;
`endif
        end
    endtask

    task automatic cyc(input logic [15:0] d, input logic [15:0] mk,
                       input logic st, input logic ct, input logic [31:0] wd);
        @(negedge clk);
        check_all();
        src_done = d;
        src_mask = mk;
        set_trigger = st;
        status_trigger = ct;
        reg_wr_data = wd;
        model_step(d, mk, st, ct, wd);
    endtask

    task automatic idle(input int n, input logic [15:0] mk);
        for (int k = 0; k < n; k++) cyc('0, mk, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        if (rstn) check_all();
        src_done = '0;
        src_mask = '0;
        set_trigger = 1'b0;
        status_trigger = 1'b0;
        reg_wr_data = '0;
        rstn = 1'b0;
        #1;
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_sw_set", 32'(sw_set), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_evt_cnt", 32'(evt_cnt), 32'h0);
        chk("rst_intr", 32'(intr_out), 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        rstn = 1'b1;
        model_step('0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        do_reset();
        idle(9, '0);
        cyc(16'h0001, '0, 1'b0, 1'b0, '0);
        idle(9, '0);
        cyc('0, '0, 1'b0, 1'b1, 32'h1);
        idle(8, '0);
        cyc('0, '0, 1'b1, 1'b0, 32'h0030_0000);
        idle(1, '0);
        cyc('0, '0, 1'b0, 1'b1, 32'h0010_0000);
        idle(2, '0);
        cyc('0, '0, 1'b0, 1'b1, 32'h0020_0000);
        idle(8, '0);
        cyc(16'h0008, '0, 1'b0, 1'b0, '0);
        idle(1, '0);
        cyc(16'h0008, '0, 1'b0, 1'b1, 32'h8);
        cyc(16'h0008, '0, 1'b0, 1'b0, '0);
        cyc(16'h0008, '0, 1'b0, 1'b0, '0);
        idle(1, '0);
        cyc('0, '0, 1'b0, 1'b1, 32'h8);
        idle(8, '0);
        cyc(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '0);
        idle(3, 16'hFFFF);
        idle(3, 16'hFF7F);
        idle(2, 16'hFFFF);
        cyc(16'h0020, 16'hFFDF, 1'b0, 1'b0, '0);
        idle(8, 16'hFFDF);
        cyc('0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        idle(2, '0);
        do_reset();
        idle(2, '0);
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] d = ($urandom_range(3) == 0) ? 16'(1 << $urandom_range(15)) : '0;
            logic [15:0] mk = ($urandom_range(20) == 0) ? 16'($urandom & $urandom) : src_mask;
            bit st = ($urandom_range(15) == 0);
            bit ct = ($urandom_range(5) == 0);
            if (k % 1000 == 999) do_reset();
            else cyc(d, mk, st, ct, $urandom);
        end
        for (int k = 0; k < 65540; k++)
            cyc(16'($urandom) | 16'h1, '0, 1'b0, ($urandom_range(3) == 0), $urandom);
        idle(4, '0);
        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
